// File: rtl/uart_msg_pkg.sv
// rtl/uart_msg_pkg.sv - shared types and constants for the UART message sender
// Purpose: FSM state type, message ROM contents and ASCII codes used by
//          uart_msg_sender and its press counter. No ports.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam int PREFIX_ROM_LEN = 7;
  localparam int DEF_DIGITS     = 3;
  // prefix + counter digits + CR + LF
  localparam int MSG_LEN        = PREFIX_ROM_LEN + DEF_DIGITS + 2;

  // "Press #"
  localparam logic [7:0] PREFIX [0:PREFIX_ROM_LEN-1] = '{
    8'h50, 8'h72, 8'h65, 8'h73, 8'h73, 8'h20, 8'h23
  };

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/uart_msg_sender_bcd_counter.sv
// rtl/uart_msg_sender_bcd_counter.sv - multi-digit BCD counter with per-digit carry
// Purpose: counts inc pulses in decimal; all-9s + 1 wraps to all-0s silently.
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset (clears to zero)
//   inc      in   one-cycle increment request
//   bcd      out  DIGITS packed BCD nibbles, least significant digit in bcd[3:0]
module bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_next;
  logic                carry;

  // Ripple the increment upward: a digit at 9 rolls to 0 and passes the carry on.
  always_comb begin
    bcd_next = bcd_q;
    carry    = inc;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_q[4*d +: 4] == 4'd9) begin
          bcd_next[4*d +: 4] = 4'd0;
        end else begin
          bcd_next[4*d +: 4] = bcd_q[4*d +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_next;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/uart_msg_sender.sv
// rtl/uart_msg_sender.sv - streams "Press #NNN\r\n" to a UART TX on each trigger
// Purpose: on an accepted start_tick, bump the decimal press counter and hand the
//          message to the UART one byte at a time over tx_start/tx_done_tick.
// Ports:
//   clk           in   system clock
//   reset_n       in   synchronous active-low reset
//   start_tick    in   one-cycle trigger (debounced button tick)
//   tx_done_tick  in   one-cycle pulse from UART TX: current byte finished
//   tx_start      out  one-cycle pulse: UART TX loads tx_data
//   tx_data       out  byte being sent, held until its tx_done_tick
//   busy          out  high while a message is in progress
//   count_bcd     out  press count as BCD nibbles
module uart_msg_sender
  import uart_msg_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int PREFIX_LEN = 7    // must not exceed the package prefix ROM
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start_tick,
  input  logic                 tx_done_tick,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [4*DIGITS-1:0]  count_bcd
);

  localparam int MSG_BYTES = PREFIX_LEN + DIGITS + 2;
  localparam int IDX_W     = $clog2(MSG_BYTES);

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       data_q;
  logic             busy_q;
  logic [7:0]       msg_byte;
  logic             accept;
  logic             last;

  // Triggers are only honoured in IDLE; anything else is dropped, not queued.
  assign accept = (state == IDLE) && start_tick;
  assign last   = (idx == IDX_W'(MSG_BYTES - 1));

  bcd_counter #(.DIGITS(DIGITS)) u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (accept),
    .bcd     (count_bcd)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start_tick)   next_state = LOAD;
      LOAD:                   next_state = SEND;
      SEND:                   next_state = WAIT;
      WAIT: if (tx_done_tick) next_state = last ? IDLE : LOAD;
      default:                next_state = IDLE;
    endcase
  end

  // Message byte selection. Digits come from the live counter, which has
  // already absorbed the accepting increment by the time LOAD runs.
  always_comb begin
    msg_byte = 8'h00;
    for (int i = 0; i < PREFIX_LEN; i++) begin
      if (idx == IDX_W'(i)) msg_byte = PREFIX[i];
    end
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IDX_W'(PREFIX_LEN + d))
        msg_byte = ASCII_ZERO | {4'h0, count_bcd[4*(DIGITS-1-d) +: 4]};
    end
    if (idx == IDX_W'(MSG_BYTES - 2)) msg_byte = ASCII_CR;
    if (idx == IDX_W'(MSG_BYTES - 1)) msg_byte = ASCII_LF;
  end

  // Byte index, held data byte and registered busy
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx    <= '0;
      data_q <= 8'h00;
      busy_q <= 1'b0;
    end else begin
      // Decoding next_state makes busy rise the cycle after acceptance.
      busy_q <= (next_state != IDLE);
      if (accept) begin
        idx <= '0;
      end else if ((state == WAIT) && tx_done_tick && !last) begin
        idx <= idx + 1'b1;
      end
      if (state == LOAD) begin
        data_q <= msg_byte;
      end
    end
  end

  // Outputs
  always_comb begin
    tx_start = (state == SEND);
    tx_data  = data_q;
    busy     = busy_q;
  end

endmodule

// File: tb/tb_uart_msg_sender.sv
// tb/tb_uart_msg_sender.sv - directed self-checking bench for uart_msg_sender
module tb_uart_msg_sender;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_main = 1'b0;
  logic        start_extra = 1'b0;
  logic        done_model = 1'b0;
  logic        done_extra = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [11:0] count_bcd;

  always #5 clk = ~clk;

  uart_msg_sender dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_tick   (start_main | start_extra),
    .tx_done_tick (done_model | done_extra),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .count_bcd    (count_bcd)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // UART TX model: answers each tx_start with tx_done after a programmable delay
  int         delay = 99;
  logic [7:0] rx[$];
  logic       pending = 1'b0;
  int         cnt = 0;
  logic [7:0] cur = 8'h00;
  logic       stable_ok = 1'b1;
  logic       hit_last = 1'b0;
  logic       extra_fired = 1'b0;
  int         cyc = 0;
  int         done_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      done_model  = 1'b0;
      start_extra = 1'b0;
      if (!reset_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (tx_data !== cur) stable_ok = 1'b0;
          if (cnt == 0) begin
            done_model = 1'b1;
            pending    = 1'b0;
            done_cyc   = cyc;
            chk("tx_data_stable", stable_ok, 1);
            if (hit_last && rx.size() == 12) begin
              start_extra = 1'b1;
              extra_fired = 1'b1;
              hit_last    = 1'b0;
            end
          end else begin
            cnt--;
          end
        end
        if (tx_start) begin
          chk("no_double_start", pending, 0);
          if (rx.size() > 0) chk("done_to_start", cyc - done_cyc, 2);
          pending   = 1'b1;
          cnt       = delay;
          cur       = tx_data;
          stable_ok = 1'b1;
          rx.push_back(tx_data);
        end
      end
    end
  end

  task automatic trigger();
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    while (busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic run_msg();
    rx.delete();
    trigger();
    wait_idle(3000);
  endtask

  task automatic check_msg(input int n);
    logic [7:0] e [12];
    e = '{8'h50, 8'h72, 8'h65, 8'h73, 8'h73, 8'h20, 8'h23,
          8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    e[7] = 8'h30 + 8'((n / 100) % 10);
    e[8] = 8'h30 + 8'((n / 10) % 10);
    e[9] = 8'h30 + 8'(n % 10);
    chk($sformatf("msg%0d_len", n), rx.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx.size()) chk($sformatf("msg%0d_byte%0d", n, i), rx[i], e[i]);
    end
  endtask

  initial begin
    // reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_count", count_bcd, 12'h000);
    reset_n = 1'b1;

    // 1: first message, latency and content
    delay = 99;
    rx.delete();
    @(negedge clk);
    start_main = 1'b1;
    @(negedge clk);
    start_main = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("no_start_t1", tx_start, 0);
    @(negedge clk);
    chk("first_start_t2", tx_start, 1);
    chk("first_byte", tx_data, 8'h50);
    wait_idle(3000);
    chk("done_before_idle", pending, 0);
    check_msg(1);
    chk("count_1", count_bcd, 12'h001);

    // 2: five spaced triggers in total
    delay = 20;
    for (int n = 2; n <= 5; n++) begin
      repeat (10) @(negedge clk);
      run_msg();
    end
    check_msg(5);
    chk("count_5", count_bcd, 12'h005);

    // 3: triggers while busy, and trigger coincident with the last done
    rx.delete();
    hit_last    = 1'b1;
    extra_fired = 1'b0;
    trigger();
    for (int k = 0; k < 3; k++) begin
      repeat (30) @(negedge clk);
      start_main = 1'b1;
      @(negedge clk);
      start_main = 1'b0;
    end
    wait_idle(3000);
    check_msg(6);
    repeat (5) @(negedge clk);
    chk("coincident_tick_sent", extra_fired, 1);
    chk("coincident_busy", busy, 0);
    chk("count_6", count_bcd, 12'h006);
    // stray tx_done while idle
    rx.delete();
    done_extra = 1'b1;
    @(negedge clk);
    done_extra = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_done_busy", busy, 0);
    chk("stray_done_no_start", rx.size(), 0);
    run_msg();
    check_msg(7);
    chk("count_7", count_bcd, 12'h007);

    // 4: run the counter up to 999 quickly, then wrap
    delay = 0;
    for (int n = 8; n <= 999; n++) run_msg();
    chk("count_999", count_bcd, 12'h999);
    check_msg(999);
    run_msg();
    check_msg(0);
    chk("count_wrap", count_bcd, 12'h000);

    // 5: reset during the WAIT of byte 5
    delay = 99;
    rx.delete();
    trigger();
    begin
      int i = 0;
      while (rx.size() < 6 && i < 3000) begin
        @(negedge clk);
        i++;
      end
    end
    chk("reach_byte5", rx.size(), 6);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_count", count_bcd, 12'h000);
    rx.delete();
    repeat (300) @(negedge clk);
    chk("no_stray_start", rx.size(), 0);
    delay = 20;
    run_msg();
    check_msg(1);
    chk("count_after_rst", count_bcd, 12'h001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
